// File: rtl/des_dec_keysched.sv
// DES key schedule for decryption: presents K16..K1 one per handshake,
// decoding each subkey combinationally from right-rotating C/D registers.
module des_dec_keysched (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
    input  logic        next,
    output logic [47:0] subkey,
    output logic [3:0]  round,
    output logic        subkey_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    state_t      state, state_n;
    logic [27:0] c, d, c_n, d_n;
    logic [3:0]  round_n;
    logic        done_n;
    logic [55:0] pc1_key;
    logic        one_step;
    logic        parity_unused;

    // DES bit n of a W-bit vector lives at index W-n.
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign pc1_key[55-i] = key[64-PC1[i]];
    end

    for (genvar i = 0; i < 48; i++) begin : g_pc2
        if (PC2[i] <= 28) begin : g_c
            assign subkey[47-i] = c[28-PC2[i]];
        end else begin : g_d
            assign subkey[47-i] = d[56-PC2[i]];
        end
    end

    assign parity_unused = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    // Undoing encryption shift s(r+1); single steps for rounds 1, 2, 9, 16.
    assign one_step = (round == 4'd0) || (round == 4'd1) ||
                      (round == 4'd8) || (round == 4'd15);

    always_comb begin
        state_n = state;
        c_n     = c;
        d_n     = d;
        round_n = round;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    c_n     = pc1_key[55:28];
                    d_n     = pc1_key[27:0];
                    round_n = 4'd15;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (next) begin
                    if (round == 4'd0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        if (one_step) begin
                            c_n = {c[0], c[27:1]};
                            d_n = {d[0], d[27:1]};
                        end else begin
                            c_n = {c[1:0], c[27:2]};
                            d_n = {d[1:0], d[27:2]};
                        end
                        round_n = round - 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            round <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            c     <= c_n;
            d     <= d_n;
            round <= round_n;
            done  <= done_n;
        end
    end

    assign subkey_valid = (state == EMIT);
    assign busy         = (state == EMIT);

endmodule

// File: tb/tb_des_dec_keysched.sv
// Directed bench for des_dec_keysched: known DES subkeys plus a forward
// (left-rotating) encryption-order schedule model for other keys.
module tb_des_dec_keysched;

    logic        clk = 1'b0;
    logic        rst, start, next;
    logic [63:0] key;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        subkey_valid, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // K1..K16 for key 133457799BBCDFF1
    logic [47:0] known [1:16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    logic [47:0] exp_ks [1:16];

    des_dec_keysched dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .next(next),
        .subkey(subkey), .round(round), .subkey_valid(subkey_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic use_known();
        for (int i = 1; i <= 16; i++) exp_ks[i] = known[i];
    endtask

    task automatic model_ks(input logic [63:0] k);
        logic [55:0] cd;
        logic [27:0] c, d;
        int s;
        for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 1; r <= 16; r++) begin
            s = (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
            for (int j = 0; j < s; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) exp_ks[r][47-i] = cd[56-PC2[i]];
        end
    endtask

    task automatic start_sched(input logic [63:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
    endtask

    // Consumes one schedule against exp_ks; returns during the done cycle.
    task automatic drain(input string tag, input bit rand_next,
                         input int poke_round, input logic [63:0] poke_key);
        int idx = 16;
        int guard = 0;
        bit nx;
        bit poked = 1'b0;
        while (idx > 0 && guard < 400) begin
            nx = rand_next ? 1'($urandom_range(0, 1)) : 1'b1;
            next = nx;
            if (poke_round >= 0 && idx - 1 == poke_round && !poked) begin
                start = 1'b1;
                key   = poke_key;
                poked = 1'b1;
            end
            check({tag, "_valid"}, subkey_valid, 1);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_subkey"}, subkey, exp_ks[idx]);
            check({tag, "_round"}, round, idx - 1);
            tick();
            start = 1'b0;
            guard++;
            if (nx) idx--;
        end
        next = 1'b0;
        if (idx != 0) check({tag, "_timeout"}, idx, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_done_valid"}, subkey_valid, 0);
        check({tag, "_done_busy"}, busy, 0);
    endtask

    task automatic finish_idle(input string tag);
        tick();
        check({tag, "_done_fall"}, done, 0);
        check({tag, "_idle_valid"}, subkey_valid, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; next = 1'b0; key = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", subkey_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_round", round, 0);
        check("rst_subkey", subkey, 0);

        next = 1'b1;
        repeat (3) tick();
        next = 1'b0;
        check("idle_next_valid", subkey_valid, 0);
        check("idle_next_round", round, 0);

        use_known();
        start_sched(KEY_A);
        drain("known", 1'b0, -1, '0);
        finish_idle("known");

        start_sched(KEY_A);
        drain("randnext", 1'b1, -1, '0);
        finish_idle("randnext");

        model_ks(64'h123456789ABCDEF1);
        start_sched(64'h123456789ABCDEF1);
        drain("par0", 1'b1, -1, '0);
        finish_idle("par0");
        start_sched(64'h123456789ABCDEF1 ^ 64'h0101010101010101);
        drain("par1", 1'b0, -1, '0);
        finish_idle("par1");

        use_known();
        start_sched(KEY_A);
        drain("restart_ign", 1'b1, 8, 64'hFEDCBA9876543210);
        finish_idle("restart_ign");

        start_sched(KEY_A);
        next = 1'b1;
        repeat (10) tick();
        check("abort_round", round, 5);
        check("abort_subkey", subkey, known[6]);
        rst = 1'b1;
        next = 1'b0;
        tick();
        rst = 1'b0;
        check("abort_valid", subkey_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_subkey0", subkey, 0);
        tick();
        check("abort_done_later", done, 0);
        start_sched(KEY_A);
        check("abort_fresh_k16", subkey, 48'hCB3D8B0E17F5);
        drain("abort_rerun", 1'b0, -1, '0);
        finish_idle("abort_rerun");

        model_ks(64'h0E329232EA6D0D73);
        start_sched(64'h0E329232EA6D0D73);
        drain("b2b_a", 1'b0, -1, '0);
        model_ks(64'hAABB09182736CCDD);
        start_sched(64'hAABB09182736CCDD);
        drain("b2b_b", 1'b1, -1, '0);
        finish_idle("b2b_b");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
